// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter and sequencer for the register-file
// write port. One grant per two cycles (IDLE -> WRITE -> IDLE). All outputs
// are registered and are loaded on the grant edge, so they are visible
// during the WRITE cycle. The busy output mirrors the FSM state.
//
// Handshake: a requester raises req[i] with its address and data and holds
// all three stable. ack[i] pulses for exactly one cycle, in the WRITE
// cycle. The requester drops req[i] by the clock edge that ends that cycle.
// A req still high at the next IDLE edge is taken as a new request.
module rf_write_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [4*N_REQ-1:0]        req_addr,
  input  logic [DATA_W*N_REQ-1:0]   req_data,
  input  logic                      stall,
  output logic [N_REQ-1:0]          ack,
  output logic [15:0]               we_onehot,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_valid,
  output logic                      drop,
  output logic                      busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   win_idx_q;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [3:0]         sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_zero_hit;
  logic [PTR_W-1:0]   ptr_d;

  // Winner search: first active request starting at ptr_q, wrapping modulo N_REQ.
  always_comb begin : pick
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) begin
        sum = sum - (PTR_W+1)'(N_REQ);
      end
      cand = sum[PTR_W-1:0];
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Mux out the winner's address and data with constant slices.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        sel_addr = req_addr[4*i +: 4];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign sel_zero_hit = ZERO_RO && (sel_addr == 4'd0);

  // Pointer advance after a grant: one past the winner, wrapping to 0.
  always_comb begin
    ptr_d = win_idx_q + 1'b1;
    if (win_idx_q == PTR_W'(N_REQ - 1)) begin
      ptr_d = '0;
    end
  end

  // FSM plus registered outputs; outputs for the WRITE cycle load on the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_idx_q <= '0;
      ack       <= '0;
      we_onehot <= '0;
      wr_data   <= '0;
      wr_valid  <= 1'b0;
      drop      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stall && sel_found) begin
            state_q   <= WRITE;
            win_idx_q <= sel_idx;
            ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
            wr_data   <= sel_data;
            busy      <= 1'b1;
            if (sel_zero_hit) begin
              we_onehot <= '0;
              wr_valid  <= 1'b0;
              drop      <= 1'b1;
            end else begin
              we_onehot <= 16'h0001 << sel_addr;
              wr_valid  <= 1'b1;
              drop      <= 1'b0;
            end
          end else begin
            ack       <= '0;
            we_onehot <= '0;
            wr_valid  <= 1'b0;
            drop      <= 1'b0;
            busy      <= 1'b0;
          end
        end
        WRITE: begin
          state_q   <= IDLE;
          ptr_q     <= ptr_d;
          ack       <= '0;
          we_onehot <= '0;
          wr_valid  <= 1'b0;
          drop      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter and sequencer for the 16-entry register-file write port. It accepts write requests (4-bit register address plus data) from up to N_REQ datapath sources: ALU writeback, load unit, immediate/move path and debug port. It grants one request at a time through a two-state FSM and drives the register file's one-hot 16-bit write-enable vector, decoded from the granted address. It sits between the execute/writeback sources and the register file, and is the only block allowed to drive register-file write enables.

## Interface
Parameters:
- N_REQ, 4: number of requesters, legal range 2..8.
- DATA_W, 8: register data width.
- ZERO_RO, 1: when 1, register 0 is read-only and writes to address 0 are dropped.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester write request, level; must be held until acked.
- req_addr  input  4*N_REQ  requester i's address in bits [4i+3:4i].
- req_data  input  DATA_W*N_REQ  requester i's data in bits [DATA_W*i+DATA_W-1:DATA_W*i].
- stall  input  1  register file busy; no new grant while high.
- ack  output  N_REQ  one-hot, one-cycle pulse to the granted requester.
- we_onehot  output  16  register write enables; at most one bit set.
- wr_data  output  DATA_W  write data, valid when wr_valid=1.
- wr_valid  output  1  a register write is occurring this cycle.
- drop  output  1  one-cycle pulse when a granted write to register 0 is suppressed.
- busy  output  1  high in the WRITE state.

## Operation
- FSM states: IDLE and WRITE. Reset state is IDLE.
- Internal registers: ptr (round-robin pointer, width ceil(log2 N_REQ)), win_idx, win_addr[3:0], win_data[DATA_W-1:0].
- IDLE:
  - If stall=0 and req≠0, select the winner: the first requester with req high, searching from ptr upward and wrapping modulo N_REQ.
  - Latch the winner's index, address and data; next state is WRITE.
  - Otherwise stay in IDLE.
- WRITE (exactly one cycle, then return to IDLE):
  - ack[win_idx]=1.
  - ptr ← (win_idx+1) mod N_REQ.
  - Normal write: we_onehot = 1<<win_addr, wr_data=win_data, wr_valid=1.
  - If ZERO_RO=1 and win_addr=0: we_onehot=0, wr_valid=0, drop=1. The requester is still acked.
- Outputs are 0 in IDLE: ack, we_onehot, wr_valid, drop, busy. wr_data may hold its last value and is don't-care when wr_valid=0.
- stall is sampled only in IDLE. A stall that rises during WRITE does not abort the write already in progress.
- Requester protocol:
  - Hold req, addr and data stable until ack.
  - Drop req at the clock edge where ack=1. req still high in the following IDLE cycle counts as a new request.
  - addr and data changes while req=1 before ack are a protocol violation; the block captures the values present on the grant edge.
- Requests arriving while in WRITE are not seen until the next IDLE cycle.

## Timing
- Reset: on rst=1 at a clock edge, the next cycle has state=IDLE, ptr=0, and all outputs 0, including wr_data.
- Reset during WRITE: the write, ack and drop are not issued in the following cycle, and the latched request is discarded.
- Latency: req high in IDLE cycle t with stall=0 gives ack, wr_valid and we_onehot in cycle t+1.
- Throughput: one write per 2 cycles; continuous requests get grants in cycles t+1, t+3, t+5, …
- Fairness: with all N_REQ requesting continuously, each requester is granted exactly once per 2*N_REQ cycles. The worst-case wait for a held request is 2*N_REQ-1 cycles with stall=0.
- Simultaneous req and stall in IDLE: no grant, and ptr is unchanged.
- Pointer wrap: a grant to N_REQ-1 sets ptr=0.

## Test plan
- Reset then single request: req=0b0010, addr1=5, data1=0xA7. Expect ack=0b0010, we_onehot=0x0020, wr_data=0xA7 and wr_valid=1 exactly one cycle after req is sampled, then IDLE.
- All four requesting continuously with distinct addresses 1, 2, 3, 4. Expect grant order 0, 1, 2, 3, 0, … on cycles 1, 3, 5, 7, 9, with we_onehot 0x0002, 0x0004, 0x0008, 0x0010.
- Round-robin from a non-zero pointer: after a grant to requester 2, assert req=0b0101. Expect the next grant to requester 0 (search order 3, 0, …), then requester 2.
- Write to register 0 with ZERO_RO=1. Expect ack pulse, drop=1, we_onehot=0x0000 and wr_valid=0. Repeat with ZERO_RO=0 and expect we_onehot=0x0001 and wr_valid=1.
- Stall held for 5 cycles with req=0b1000. Expect no ack while stall=1. Deassert stall and expect ack[3] one cycle later.
- rst asserted in a WRITE cycle. Expect no ack, we_onehot=0 and ptr=0 afterward. A re-asserted request is then granted normally.
